uart_tx_fifo_drain: RTL and testbench
=====================================

# uart_tx_fifo_drain

Read-side consumer for the character FIFO (8-bit, standard read mode, one-cycle read latency). When enabled, it pops one byte at a time from the FIFO and serializes each byte onto a UART line as 8N1, LSB first. It sits between the FIFO read port and the board TX pin, and completes the FIFO's write-from-receiver / read-to-transmitter path.

## Interface
Parameters:
- CLKS_PER_BIT, 1085: CLK cycles per UART bit (125 MHz / 115200). Legal range 2..65535.

Ports:
- CLK  in  1  system clock, the single clock domain; FIFO rd_clk is the same clock.
- RST_N  in  1  reset, asynchronous, active-low.
- ENABLE  in  1  allow new frames to start (e.g. SW0); sampled only in IDLE.
- FIFO_EMPTY  in  1  FIFO empty flag.
- FIFO_RST_BUSY  in  1  FIFO rd_rst_busy; no pop while high.
- FIFO_DOUT  in  8  FIFO read data, valid the cycle after a pop.
- FIFO_RD_EN  out  1  FIFO read enable; one-cycle pulse per byte.
- TXD  out  1  UART serial output; idle high.
- BUSY  out  1  high whenever the state is not IDLE.
- TX_DONE  out  1  one-cycle pulse after each stop bit completes.

## Operation
- States: IDLE, POP, LOAD, START, DATA, STOP. All outputs are registered or decoded directly from the state.
- IDLE: TXD=1. The block moves to POP when ENABLE=1, FIFO_EMPTY=0 and FIFO_RST_BUSY=0 are all true in the same cycle. Otherwise it stays in IDLE.
- POP: lasts 1 cycle, with FIFO_RD_EN=1 only in this state. Next state is LOAD.
- LOAD: lasts 1 cycle. At the end of LOAD, FIFO_DOUT is captured into an 8-bit shift register, and the bit counter and baud counter are cleared. Next state is START.
- START: TXD=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: transmits 8 bits, LSB first. Each bit is held for CLKS_PER_BIT cycles, and the register shifts right at the end of each bit. The 3-bit index goes 0..7; the block moves to STOP after index 7.
- STOP: TXD=1 for CLKS_PER_BIT cycles. TX_DONE=1 during the final cycle of STOP. Next state is IDLE.
- Baud counter: 16 bits. It counts 0..CLKS_PER_BIT-1, reloads to 0 on each bit boundary, and never wraps mid-bit.
- ENABLE falling during POP..STOP: the current frame completes normally and no further pops occur.
- FIFO_EMPTY or FIFO_RST_BUSY changing after POP: ignored for the current frame.
- FIFO_EMPTY=1 while in IDLE: no pop occurs, so there is never a read of an empty FIFO.
- Reset (RST_N=0) at any time: immediately forces IDLE with TXD=1, FIFO_RD_EN=0, BUSY=0 and TX_DONE=0. A partially sent byte is dropped and is not re-sent.

## Timing
- Reset values: TXD=1, FIFO_RD_EN=0, BUSY=0, TX_DONE=0, shift register=0x00, counters=0.
- Pop to start bit: FIFO_RD_EN is high in cycle t; TXD falls at cycle t+2.
- Frame length: exactly 10*CLKS_PER_BIT cycles from TXD falling to the end of the stop bit.
- BUSY: rises the cycle after IDLE detects the start condition (the POP cycle) and falls on entry to IDLE.
- Back-to-back bytes: after the last STOP cycle, the block spends 1 cycle in IDLE, then POP, then LOAD. That gives 3 extra TXD-high cycles between frames, so the falling-edge to falling-edge period is 10*CLKS_PER_BIT+3 cycles.
- TX_DONE and FIFO_RD_EN are never high in the same cycle.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Single byte: FIFO holds 0x95 and ENABLE=1 → one FIFO_RD_EN pulse. TXD per bit = 0,1,0,1,0,1,0,0,1,1, with each level held for 4 cycles. TX_DONE pulses in cycle 40 after TXD falls. BUSY then returns to 0 and TXD stays 1.
- Back-to-back: FIFO holds 0x00 then 0xFF → two pops. TXD falling edges are exactly 43 cycles apart. Data bits read all-0, then all-1.
- Gating: FIFO non-empty with ENABLE=0 → no FIFO_RD_EN and TXD stays 1. Raising ENABLE causes FIFO_RD_EN in the next cycle. Dropping ENABLE mid-frame still produces the full 40-cycle frame and no second pop.
- Empty / reset-busy: FIFO_EMPTY=1, or FIFO_RST_BUSY=1, held for 100 cycles → FIFO_RD_EN=0 and BUSY=0 throughout.
- Reset mid-frame: assert RST_N=0 during data bit 3 of 0xA5 → TXD=1 and BUSY=0 with no clock edge required. After release, TXD stays high until the next pop.
- Large divider: with CLKS_PER_BIT=1085, one byte 0x55 → frame length is 10850 cycles and every bit holds exactly 1085 cycles.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
// FIFO-to-UART drain: pops one byte at a time from a standard-mode FIFO and
// sends each byte as 8N1, LSB first.
module uart_tx_fifo_drain #(
    parameter int unsigned CLKS_PER_BIT = 1085
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       ENABLE,
    input  logic       FIFO_EMPTY,
    input  logic       FIFO_RST_BUSY,
    input  logic [7:0] FIFO_DOUT,
    output logic       FIFO_RD_EN,
    output logic       TXD,
    output logic       BUSY,
    output logic       TX_DONE
);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] baud;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        bit_end;

    assign bit_end = (baud == BAUD_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (ENABLE && !FIFO_EMPTY && !FIFO_RST_BUSY) state_next = POP;
            POP:   state_next = LOAD;
            LOAD:  state_next = START;
            START: if (bit_end) state_next = DATA;
            DATA:  if (bit_end && bit_idx == 3'd7) state_next = STOP;
            STOP:  if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FIFO_DOUT is valid in LOAD, one cycle after the POP read strobe.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            unique case (state)
                LOAD: begin
                    shreg   <= FIFO_DOUT;
                    baud    <= '0;
                    bit_idx <= '0;
                end
                START, STOP: begin
                    baud <= bit_end ? '0 : baud + 16'd1;
                end
                DATA: begin
                    if (bit_end) begin
                        baud    <= '0;
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                default: begin
                    baud <= '0;
                end
            endcase
        end
    end

    always_comb begin
        FIFO_RD_EN = (state == POP);
        BUSY       = (state != IDLE);
        TX_DONE    = (state == STOP) && bit_end;
        unique case (state)
            START:   TXD = 1'b0;
            DATA:    TXD = shreg[0];
            default: TXD = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: frame-timing model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_uart_tx_fifo_drain;

    localparam int N  = 4;
    localparam int NB = 1085;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       fifo_empty = 1'b1;
    logic       fifo_rst_busy;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_rd_en, txd, busy, tx_done;

    logic       big_enable;
    logic       big_empty;
    logic       big_rst_busy = 1'b0;
    logic [7:0] big_dout = 8'h55;
    logic       big_rd_en, big_txd, big_busy, big_done;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo_drain #(.CLKS_PER_BIT(N)) u_dut (
        .CLK(clk), .RST_N(rst_n), .ENABLE(enable), .FIFO_EMPTY(fifo_empty),
        .FIFO_RST_BUSY(fifo_rst_busy), .FIFO_DOUT(fifo_dout),
        .FIFO_RD_EN(fifo_rd_en), .TXD(txd), .BUSY(busy), .TX_DONE(tx_done)
    );

    uart_tx_fifo_drain #(.CLKS_PER_BIT(NB)) u_big (
        .CLK(clk), .RST_N(rst_n), .ENABLE(big_enable), .FIFO_EMPTY(big_empty),
        .FIFO_RST_BUSY(big_rst_busy), .FIFO_DOUT(big_dout),
        .FIFO_RD_EN(big_rd_en), .TXD(big_txd), .BUSY(big_busy), .TX_DONE(big_done)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO with one-cycle read latency; empty flag updates at the clock edge.
    logic [7:0] q[$];
    always @(posedge clk) begin
        if (fifo_rd_en && q.size() > 0) fifo_dout <= q.pop_front();
        fifo_empty <= (q.size() == 0);
    end

    // Monitors for the small-divider instance
    int  falls[$];
    int  dones[$];
    int  rd_cycles[$];
    int  busy_cnt = 0;
    bit  txd_hist[0:8191];
    logic prev_txd = 1'b1;
    always @(negedge clk) begin
        if (cyc < 8192) txd_hist[cyc] = txd;
        if (prev_txd && !txd) falls.push_back(cyc);
        if (tx_done) dones.push_back(cyc);
        if (fifo_rd_en) rd_cycles.push_back(cyc);
        if (busy) busy_cnt++;
        prev_txd = txd;
    end

    // Monitors for the large-divider instance
    int   big_edges[$];
    int   big_dones[$];
    int   big_rds[$];
    logic prev_big = 1'b1;
    always @(negedge clk) begin
        if (prev_big != big_txd) big_edges.push_back(cyc);
        if (big_done) big_dones.push_back(cyc);
        if (big_rd_en) big_rds.push_back(cyc);
        prev_big = big_txd;
    end

    // Frame model: a pop decided in idle cycle c gives POP at c+1, start bit
    // at c+3, and 10 bits of N cycles each; the block is idle again right after.
    bit         model_on = 1'b0;
    bit         have_frame = 1'b0;
    int         m_pop, m_start;
    logic [7:0] m_byte;
    always @(negedge clk) begin
        int   k, fend;
        logic e_txd, e_busy, e_rd, e_done;
        if (model_on) begin
            if (!rst_n) begin
                have_frame = 1'b0;
                check("rst_txd", txd, 1);
                check("rst_busy", busy, 0);
                check("rst_rd_en", fifo_rd_en, 0);
                check("rst_tx_done", tx_done, 0);
            end else begin
                e_txd = 1'b1; e_busy = 1'b0; e_rd = 1'b0; e_done = 1'b0;
                fend = have_frame ? m_start + 10 * N : 0;
                if (have_frame) begin
                    if (cyc >= m_start && cyc < fend) begin
                        k = (cyc - m_start) / N;
                        e_txd = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : m_byte[k-1];
                    end
                    e_busy = (cyc >= m_pop) && (cyc < fend);
                    e_rd   = (cyc == m_pop);
                    e_done = (cyc == fend - 1);
                end
                check("model_txd", txd, e_txd);
                check("model_busy", busy, e_busy);
                check("model_rd_en", fifo_rd_en, e_rd);
                check("model_tx_done", tx_done, e_done);
                if ((!have_frame || cyc >= fend) && enable && !fifo_empty && !fifo_rst_busy) begin
                    have_frame = 1'b1;
                    m_pop   = cyc + 1;
                    m_start = cyc + 3;
                    m_byte  = (q.size() > 0) ? q[0] : 8'h00;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        falls.delete(); dones.delete(); rd_cycles.delete();
    endtask

    task automatic wait_dones(input int want, input int limit, input string name);
        int i = 0;
        while (dones.size() < want && i < limit) begin tick(1); i++; end
        check(name, dones.size(), want);
    endtask

    initial begin : timeout
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [9:0] exp95;
        int f, t_raise, busy0, i;
        exp95 = 10'b11_0010_1010;

        rst_n = 1'b0; enable = 1'b0; fifo_rst_busy = 1'b0;
        big_enable = 1'b0; big_empty = 1'b1;
        tick(3);
        check("reset_txd", txd, 1);
        check("reset_busy", busy, 0);
        check("reset_rd_en", fifo_rd_en, 0);
        check("reset_tx_done", tx_done, 0);
        rst_n = 1'b1;
        model_on = 1'b1;
        tick(2);

        // Single byte 0x95
        clear_mon();
        q.push_back(8'h95);
        enable = 1'b1;
        wait_dones(1, 100, "single_done_seen");
        tick(5);
        check("single_pops", rd_cycles.size(), 1);
        if (falls.size() > 0 && rd_cycles.size() > 0 && dones.size() > 0) begin
            f = falls[0];
            check("single_pop_to_start", f - rd_cycles[0], 2);
            check("single_done_offset", dones[0] - f, 39);
            for (int b = 0; b < 10; b++)
                for (int j = 0; j < N; j++)
                    check($sformatf("single_bit%0d_c%0d", b, j), txd_hist[f + b * N + j], exp95[b]);
        end
        check("single_busy_after", busy, 0);
        check("single_txd_after", txd, 1);
        enable = 1'b0;
        tick(3);

        // Back-to-back 0x00, 0xFF
        clear_mon();
        q.push_back(8'h00);
        q.push_back(8'hFF);
        enable = 1'b1;
        wait_dones(2, 200, "b2b_dones_seen");
        tick(3);
        check("b2b_pops", rd_cycles.size(), 2);
        if (falls.size() == 2) begin
            check("b2b_period", falls[1] - falls[0], 43);
            for (int b = 0; b < 8; b++) begin
                check($sformatf("b2b_f0_bit%0d", b), txd_hist[falls[0] + (b + 1) * N + 2], 0);
                check($sformatf("b2b_f1_bit%0d", b), txd_hist[falls[1] + (b + 1) * N + 2], 1);
            end
        end else begin
            check("b2b_falls", falls.size(), 2);
        end
        enable = 1'b0;
        tick(3);

        // Gating by ENABLE
        clear_mon();
        q.push_back(8'hA3);
        q.push_back(8'h3C);
        tick(20);
        check("gate_no_pop", rd_cycles.size(), 0);
        check("gate_txd_idle", txd, 1);
        t_raise = cyc;
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        tick(1);
        check("gate_pop_count", rd_cycles.size(), 1);
        if (rd_cycles.size() > 0) check("gate_pop_next_cycle", rd_cycles[0], t_raise + 1);
        wait_dones(1, 100, "gate_done_seen");
        tick(20);
        check("gate_single_pop", rd_cycles.size(), 1);
        if (falls.size() > 0 && dones.size() > 0) check("gate_frame_len", dones[0] - falls[0], 39);

        // Empty FIFO, then reset-busy FIFO
        q.delete();
        tick(2);
        clear_mon();
        enable = 1'b1;
        busy0 = busy_cnt;
        tick(100);
        check("empty_no_pop", rd_cycles.size(), 0);
        check("empty_no_busy", busy_cnt - busy0, 0);
        fifo_rst_busy = 1'b1;
        q.push_back(8'h5A);
        busy0 = busy_cnt;
        tick(100);
        check("rstbusy_no_pop", rd_cycles.size(), 0);
        check("rstbusy_no_busy", busy_cnt - busy0, 0);
        fifo_rst_busy = 1'b0;
        wait_dones(1, 100, "rstbusy_release_done");
        check("rstbusy_release_pop", rd_cycles.size(), 1);
        enable = 1'b0;
        tick(3);

        // Reset during data bit 3 of 0xA5 (bit value 0)
        clear_mon();
        q.push_back(8'hA5);
        enable = 1'b1;
        i = 0;
        while (falls.size() == 0 && i < 50) begin tick(1); i++; end
        check("rstmid_frame_started", falls.size(), 1);
        if (falls.size() > 0) begin
            f = falls[0];
            while (cyc < f + 17) tick(1);
            check("rstmid_bit3_low", txd, 0);
            rst_n = 1'b0;
            #1;
            check("rstmid_txd_async", txd, 1);
            check("rstmid_busy_async", busy, 0);
            tick(2);
            rst_n = 1'b1;
            tick(30);
            check("rstmid_txd_after", txd, 1);
            check("rstmid_no_resend", rd_cycles.size(), 1);
            check("rstmid_no_done", dones.size(), 0);
        end
        enable = 1'b0;
        tick(3);

        // Large divider, byte 0x55: every bit alternates, so edges mark bit boundaries
        big_empty = 1'b0;
        big_enable = 1'b1;
        i = 0;
        while (big_rds.size() == 0 && i < 20) begin tick(1); i++; end
        big_empty = 1'b1;
        check("big_pop_seen", big_rds.size(), 1);
        i = 0;
        while (big_dones.size() == 0 && i < 11000) begin tick(1); i++; end
        check("big_done_seen", big_dones.size(), 1);
        tick(10);
        check("big_pops", big_rds.size(), 1);
        check("big_edge_count", big_edges.size(), 10);
        if (big_edges.size() == 10 && big_dones.size() == 1 && big_rds.size() == 1) begin
            check("big_pop_to_start", big_edges[0] - big_rds[0], 2);
            for (int b = 1; b < 10; b++)
                check($sformatf("big_bit%0d_len", b - 1), big_edges[b] - big_edges[b-1], NB);
            check("big_frame_len", big_dones[0] - big_edges[0] + 1, 10 * NB);
        end
        check("big_txd_after", big_txd, 1);
        check("big_busy_after", big_busy, 0);
        big_enable = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
